// File: rtl/debug_instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// debug_instr_loader_pkg
// Host command opcodes, loader FSM states and default timeout.
// Rev 1.0
// ============================================================================
package debug_instr_loader_pkg;

    localparam logic [7:0] CMD_LOAD    = 8'h01;
    localparam logic [7:0] CMD_STEP    = 8'h02;
    localparam logic [7:0] CMD_RUN     = 8'h03;
    localparam logic [7:0] CMD_HALT    = 8'h04;
    localparam logic [7:0] CMD_CLR_ERR = 8'h05;

    localparam int DEF_TIMEOUT_CYC = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEN_HI = 2'd1,
        ST_LEN_LO = 2'd2,
        ST_DATA   = 2'd3
    } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/debug_instr_loader_timeout_cnt.sv
`default_nettype none
// ============================================================================
// debug_instr_loader_timeout_cnt
// Idle-cycle counter; o_expired flags the TIMEOUT_CYC-th consecutive idle cycle.
// Rev 1.0
// ============================================================================
module debug_instr_loader_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int NB_TIMEOUT  = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [NB_TIMEOUT-1:0] r_cnt;
    logic                  w_expired;

    // Expiry is combinational so the FSM reacts in the same cycle the limit is hit.
    assign w_expired = i_en && !i_clr && (r_cnt == NB_TIMEOUT'(TIMEOUT_CYC - 1));
    assign o_expired = w_expired;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_expired) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + NB_TIMEOUT'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_instr_loader.sv
`default_nettype none
// ============================================================================
// debug_instr_loader
// Decodes host byte commands and writes assembled words into the fetch RAM.
// Rev 1.0
// ============================================================================
module debug_instr_loader
    import debug_instr_loader_pkg::*;
#(
    parameter int NB_BITS     = 32,
    parameter int NB_BYTE     = 8,
    parameter int RAM_DEPTH   = 10,
    parameter int NB_WCNT     = 16,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int NB_TIMEOUT  = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NB_BYTE-1:0]   i_rx_data,
    input  logic                 i_rx_valid,
    output logic [NB_BITS-1:0]   o_data_debug,
    output logic [RAM_DEPTH-1:0] o_addr_debug,
    output logic                 o_wren_debug,
    output logic                 o_debug,
    output logic                 o_step,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
);

    localparam int BYTES_PER_WORD = NB_BITS / NB_BYTE;
    localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    ld_state_e              r_state,      w_state_nxt;
    logic [NB_WCNT-1:0]     r_wcnt,       w_wcnt_nxt;
    logic [NB_WCNT-1:0]     r_words_done, w_words_done_nxt;
    logic [RAM_DEPTH-1:0]   r_widx,       w_widx_nxt;
    logic [NB_BCNT-1:0]     r_bcnt,       w_bcnt_nxt;
    logic [NB_BITS-1:0]     r_shift,      w_shift_nxt;
    logic [NB_BITS-1:0]     r_data,       w_data_nxt;
    logic [RAM_DEPTH-1:0]   r_addr,       w_addr_nxt;
    logic                   r_wren,       w_wren_nxt;
    logic                   r_debug,      w_debug_nxt;
    logic                   r_step,       w_step_nxt;
    logic                   r_done,       w_done_nxt;
    logic                   r_error,      w_error_nxt;

    logic [NB_BITS-1:0]     w_word;
    logic [NB_WCNT-1:0]     w_len;
    logic [NB_WCNT-1:0]     w_words_inc;
    logic                   w_to_clr;
    logic                   w_to_en;
    logic                   w_expired;

    assign w_word      = {r_shift[NB_BITS-NB_BYTE-1:0], i_rx_data};
    assign w_len       = {r_wcnt[NB_WCNT-NB_BYTE-1:0], i_rx_data};
    assign w_words_inc = r_words_done + NB_WCNT'(1);

    assign w_to_clr = (r_state == ST_IDLE) || i_rx_valid;
    assign w_to_en  = !w_to_clr;

    debug_instr_loader_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .NB_TIMEOUT  (NB_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_to_clr),
        .i_en      (w_to_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_wcnt_nxt       = r_wcnt;
        w_words_done_nxt = r_words_done;
        w_widx_nxt       = r_widx;
        w_bcnt_nxt       = r_bcnt;
        w_shift_nxt      = r_shift;
        w_data_nxt       = r_data;
        w_addr_nxt       = r_addr;
        w_wren_nxt       = 1'b0;
        w_debug_nxt      = r_debug;
        w_step_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_error_nxt      = r_error;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        NB_BYTE'(CMD_LOAD): begin
                            w_state_nxt = ST_LEN_HI;
                            w_debug_nxt = 1'b1;
                        end
                        NB_BYTE'(CMD_STEP):    w_step_nxt  = r_debug;
                        NB_BYTE'(CMD_RUN):     w_debug_nxt = 1'b0;
                        NB_BYTE'(CMD_HALT):    w_debug_nxt = 1'b1;
                        NB_BYTE'(CMD_CLR_ERR): w_error_nxt = 1'b0;
                        default:               w_error_nxt = 1'b1;
                    endcase
                end
            end

            ST_LEN_HI: begin
                if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                end else if (i_rx_valid) begin
                    w_wcnt_nxt  = w_len;
                    w_state_nxt = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                end else if (i_rx_valid) begin
                    w_wcnt_nxt       = w_len;
                    w_bcnt_nxt       = '0;
                    w_widx_nxt       = '0;
                    w_words_done_nxt = '0;
                    if (w_len == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_error_nxt = 1'b1;
                    w_bcnt_nxt  = '0;
                end else if (i_rx_valid) begin
                    w_shift_nxt = w_word;
                    if (r_bcnt == NB_BCNT'(BYTES_PER_WORD - 1)) begin
                        w_bcnt_nxt       = '0;
                        w_wren_nxt       = 1'b1;
                        w_data_nxt       = w_word;
                        w_addr_nxt       = r_widx;
                        w_widx_nxt       = r_widx + RAM_DEPTH'(1);
                        w_words_done_nxt = w_words_inc;
                        if (w_words_inc == r_wcnt) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_bcnt_nxt = r_bcnt + NB_BCNT'(1);
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_wcnt       <= '0;
            r_words_done <= '0;
            r_widx       <= '0;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_addr       <= '0;
            r_wren       <= 1'b0;
            r_debug      <= 1'b1;
            r_step       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_words_done <= w_words_done_nxt;
            r_widx       <= w_widx_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_data       <= w_data_nxt;
            r_addr       <= w_addr_nxt;
            r_wren       <= w_wren_nxt;
            r_debug      <= w_debug_nxt;
            r_step       <= w_step_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign o_data_debug = r_data;
    assign o_addr_debug = r_addr;
    assign o_wren_debug = r_wren;
    assign o_debug      = r_debug;
    assign o_step       = r_step;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_debug_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_debug_instr_loader
// Scoreboard bench for the fetch-RAM debug loader.
// Rev 1.0
// ============================================================================
module tb_debug_instr_loader;

    localparam int NB_BITS     = 32;
    localparam int NB_BYTE     = 8;
    localparam int RAM_DEPTH   = 10;
    localparam int NB_WCNT     = 16;
    localparam int TIMEOUT_CYC = 40;
    localparam int NB_TIMEOUT  = 8;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b0;
    logic [NB_BYTE-1:0]   i_rx_data = '0;
    logic                 i_rx_valid = 1'b0;
    logic [NB_BITS-1:0]   o_data_debug;
    logic [RAM_DEPTH-1:0] o_addr_debug;
    logic                 o_wren_debug;
    logic                 o_debug;
    logic                 o_step;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    debug_instr_loader #(
        .NB_BITS     (NB_BITS),
        .NB_BYTE     (NB_BYTE),
        .RAM_DEPTH   (RAM_DEPTH),
        .NB_WCNT     (NB_WCNT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .NB_TIMEOUT  (NB_TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_data_debug (o_data_debug),
        .o_addr_debug (o_addr_debug),
        .o_wren_debug (o_wren_debug),
        .o_debug      (o_debug),
        .o_step       (o_step),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [NB_BITS-1:0]   data;
        logic [RAM_DEPTH-1:0] addr;
        logic                 done;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] tx_q[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int wren_cnt  = 0;
    int done_cnt  = 0;
    int step_cnt  = 0;

    always @(negedge i_clk) begin
        if (o_step) step_cnt++;
        if (o_done) done_cnt++;
        if (o_wren_debug) begin
            wren_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got data=%h addr=%0d, required no write", o_data_debug, o_addr_debug);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_data_debug !== mon_e.data || o_addr_debug !== mon_e.addr || o_done !== mon_e.done) begin
                    n_fail++;
                    $display("FAIL wr_check: got data=%h addr=%0d done=%b, required data=%h addr=%0d done=%b",
                             o_data_debug, o_addr_debug, o_done, mon_e.data, mon_e.addr, mon_e.done);
                end
            end
        end
    end

    task automatic flush_tx;
        while (tx_q.size() > 0) begin
            @(negedge i_clk);
            i_rx_data  = tx_q.pop_front();
            i_rx_valid = 1'b1;
        end
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((o_busy || exp_q.size() != 0) && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL %s_drain: busy=%b pending=%0d, required idle with 0 pending", name, o_busy, exp_q.size());
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++; if (o_data_debug !== '0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", o_data_debug); end
        n_checks++; if (o_addr_debug !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d, required 0", o_addr_debug); end
        n_checks++; if (o_wren_debug !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b, required 0", o_wren_debug); end
        n_checks++; if (o_debug !== 1'b1) begin n_fail++; $display("FAIL rst_debug: got %b, required 1", o_debug); end
        n_checks++; if (o_step !== 1'b0) begin n_fail++; $display("FAIL rst_step: got %b, required 0", o_step); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", o_done); end
        n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b, required 0", o_error); end
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_load_basic;
        int w0 = wren_cnt;
        int d0 = done_cnt;
        exp_q.push_back('{32'hDEADBEEF, 10'd0, 1'b0});
        exp_q.push_back('{32'h00000020, 10'd1, 1'b1});
        tx_q = {8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h20};
        flush_tx();
        wait_drain("load_basic");
        n_checks++; if (wren_cnt - w0 != 2) begin n_fail++; $display("FAIL basic_wren_cnt: got %0d, required 2", wren_cnt - w0); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d, required 1", done_cnt - d0); end
        n_checks++; if (o_data_debug !== 32'h00000020 || o_addr_debug !== 10'd1) begin
            n_fail++; $display("FAIL basic_hold: got data=%h addr=%0d, required 00000020 @1", o_data_debug, o_addr_debug);
        end
    endtask

    task automatic test_load_zero;
        int w0;
        int d0;
        tx_q = {8'h03};
        flush_tx();
        n_checks++; if (o_debug !== 1'b0) begin n_fail++; $display("FAIL run_debug: got %b, required 0", o_debug); end
        w0 = wren_cnt;
        d0 = done_cnt;
        tx_q = {8'h01, 8'h00, 8'h00};
        flush_tx();
        n_checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_done_busy: got done=%b busy=%b, required done=1 busy=0", o_done, o_busy);
        end
        repeat (3) @(negedge i_clk);
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d, required 1", done_cnt - d0); end
        n_checks++; if (wren_cnt != w0) begin n_fail++; $display("FAIL zero_wren: got %0d writes, required 0", wren_cnt - w0); end
        n_checks++; if (o_debug !== 1'b1) begin n_fail++; $display("FAIL load_sets_debug: got %b, required 1", o_debug); end
    endtask

    task automatic test_step;
        int s0;
        tx_q = {8'h04};
        flush_tx();
        s0 = step_cnt;
        tx_q = {8'h02};
        flush_tx();
        n_checks++; if (o_step !== 1'b1) begin n_fail++; $display("FAIL step_high: got %b, required 1", o_step); end
        @(negedge i_clk);
        n_checks++; if (o_step !== 1'b0) begin n_fail++; $display("FAIL step_low: got %b, required 0", o_step); end
        repeat (2) @(negedge i_clk);
        n_checks++; if (step_cnt - s0 != 1) begin n_fail++; $display("FAIL step_width: got %0d cycles, required 1", step_cnt - s0); end
        tx_q = {8'h03, 8'h02};
        s0 = step_cnt;
        flush_tx();
        repeat (3) @(negedge i_clk);
        n_checks++; if (o_debug !== 1'b0) begin n_fail++; $display("FAIL run_debug2: got %b, required 0", o_debug); end
        n_checks++; if (step_cnt != s0) begin n_fail++; $display("FAIL step_in_run: got %0d cycles, required 0", step_cnt - s0); end
    endtask

    task automatic test_timeout;
        int w0 = wren_cnt;
        tx_q = {8'h01, 8'h00, 8'h01, 8'h12, 8'h34};
        flush_tx();
        repeat (TIMEOUT_CYC - 1) @(negedge i_clk);
        n_checks++; if (o_error !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL to_early: got error=%b busy=%b, required error=0 busy=1", o_error, o_busy);
        end
        @(negedge i_clk);
        n_checks++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL to_expire: got error=%b busy=%b, required error=1 busy=0", o_error, o_busy);
        end
        repeat (3) @(negedge i_clk);
        n_checks++; if (wren_cnt != w0) begin n_fail++; $display("FAIL to_nowrite: got %0d writes, required 0", wren_cnt - w0); end
        tx_q = {8'h05};
        flush_tx();
        n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b, required 0", o_error); end
    endtask

    task automatic test_wrap;
        int w0 = wren_cnt;
        int d0 = done_cnt;
        int n  = (1 << RAM_DEPTH) + 1;
        logic [31:0] w = '0;
        tx_q = {8'h01, 8'(n >> 8), 8'(n)};
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            tx_q.push_back(w[31:24]);
            tx_q.push_back(w[23:16]);
            tx_q.push_back(w[15:8]);
            tx_q.push_back(w[7:0]);
            exp_q.push_back('{w, RAM_DEPTH'(i), (i == n - 1)});
        end
        flush_tx();
        wait_drain("wrap");
        n_checks++; if (wren_cnt - w0 != n) begin n_fail++; $display("FAIL wrap_cnt: got %0d, required %0d", wren_cnt - w0, n); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL wrap_done: got %0d, required 1", done_cnt - d0); end
        n_checks++; if (o_addr_debug !== '0 || o_data_debug !== w) begin
            n_fail++; $display("FAIL wrap_last: got %h @%0d, required %h @0", o_data_debug, o_addr_debug, w);
        end
        tx_q = {8'h7F};
        flush_tx();
        n_checks++; if (o_error !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL bad_cmd: got error=%b busy=%b, required error=1 busy=0", o_error, o_busy);
        end
        tx_q = {8'h05};
        flush_tx();
    endtask

    task automatic test_reset_mid_load;
        int w0;
        int d0;
        tx_q = {8'h7F, 8'h01, 8'h00, 8'h03, 8'hAA, 8'hBB};
        flush_tx();
        n_checks++; if (o_busy !== 1'b1 || o_error !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got busy=%b error=%b, required busy=1 error=1", o_busy, o_error);
        end
        #2 i_rst = 1'b0;
        #1;
        n_checks++; if (o_busy !== 1'b0 || o_error !== 1'b0 || o_debug !== 1'b1) begin
            n_fail++; $display("FAIL mid_async: got busy=%b error=%b debug=%b, required 0 0 1", o_busy, o_error, o_debug);
        end
        n_checks++; if (o_data_debug !== '0 || o_addr_debug !== '0) begin
            n_fail++; $display("FAIL mid_async_dp: got data=%h addr=%0d, required 0 @0", o_data_debug, o_addr_debug);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        w0 = wren_cnt;
        d0 = done_cnt;
        exp_q.push_back('{32'h11223344, 10'd0, 1'b1});
        tx_q = {8'h01, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        flush_tx();
        wait_drain("post_reset");
        n_checks++; if (wren_cnt - w0 != 1 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL post_reset_cnt: got wren=%0d done=%0d, required 1 1", wren_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_basic();
        test_load_zero();
        test_step();
        test_timeout();
        test_wrap();
        test_reset_mid_load();
        repeat (3) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
